// File: rtl/aer_pkg.sv
// ---------------------------------------------------------------------------
// aer_pkg
// Shared types and constants for the AER output link arbiter.
//   aer_state_t        : handshake FSM states
//   req_id_t           : requester identity (encoder / host); its value is
//                        also the index of that requester's slot
//   AER_ADDR_W_DEFAULT : default AER address width
//   rr_pick()          : round-robin winner selection between the two slots
// ---------------------------------------------------------------------------
package aer_pkg;

    localparam int AER_ADDR_W_DEFAULT = 10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARB    = 3'd1,
        REQ_HI = 3'd2,
        REQ_LO = 3'd3,
        ERROR  = 3'd4
    } aer_state_t;

    typedef enum logic {
        REQ_ENC  = 1'b0,
        REQ_HOST = 1'b1
    } req_id_t;

    // A lone full slot always wins. When both are full, the winner is the
    // requester the round-robin pointer currently prefers; the pointer is
    // moved to the other requester after every completed transfer.
    function automatic req_id_t rr_pick(
        input logic    enc_full,
        input logic    host_full,
        input req_id_t prefer
    );
        if (enc_full && host_full) begin
            return prefer;
        end else if (host_full) begin
            return REQ_HOST;
        end else begin
            return REQ_ENC;
        end
    endfunction

endpackage

// File: rtl/aer_req_slot.sv
// ---------------------------------------------------------------------------
// aer_req_slot
// One-entry holding slot for a single AER requester. An event is captured
// when IN_VALID is high while the slot is empty; it stays until DROP.
//
// Ports
//   CLK       in   rising-edge clock
//   RSTN      in   asynchronous active-low reset (slot empties)
//   IN_VALID  in   requester has an event
//   IN_ADDR   in   requester event address
//   IN_READY  out  slot empty, a new event may be offered
//   DROP      in   release the held event (completion or timeout)
//   FULL      out  slot holds an event
//   ADDR      out  address of the held event
// ---------------------------------------------------------------------------
module aer_req_slot
    import aer_pkg::*;
#(
    parameter int ADDR_W = AER_ADDR_W_DEFAULT
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              IN_VALID,
    input  logic [ADDR_W-1:0] IN_ADDR,
    output logic              IN_READY,
    input  logic              DROP,
    output logic              FULL,
    output logic [ADDR_W-1:0] ADDR
);

    logic              full_reg;
    logic              full_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] addr_next;
    logic              capture;

    // Capture only into an empty slot, so a held event is never overwritten.
    assign capture = IN_VALID && !full_reg;

    always_comb begin
        full_next = full_reg;
        addr_next = addr_reg;
        // DROP only targets a full slot and capture only an empty one, so
        // the two can never collide.
        if (DROP) begin
            full_next = 1'b0;
        end else if (capture) begin
            full_next = 1'b1;
            addr_next = IN_ADDR;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            full_reg <= 1'b0;
            addr_reg <= '0;
        end else begin
            full_reg <= full_next;
            addr_reg <= addr_next;
        end
    end

    assign IN_READY = !full_reg;
    assign FULL     = full_reg;
    assign ADDR     = addr_reg;

endmodule

// File: rtl/aer_link_arbiter.sv
// ---------------------------------------------------------------------------
// aer_link_arbiter
// Merges events from a spike encoder and from the host/config path onto a
// single four-phase AER output link. Each requester has a one-entry slot;
// a round-robin FSM picks a winner, drives REQ/ADDR and waits for the
// acknowledge. Each handshake phase is guarded by a timeout that drops the
// event and raises a sticky ERR until software clears it.
//
// Ports
//   CLK          in   rising-edge clock
//   RSTN         in   asynchronous active-low reset
//   ENC_VALID    in   encoder event offer
//   ENC_ADDR     in   encoder event address
//   ENC_READY    out  encoder slot empty
//   HOST_VALID   in   host event offer
//   HOST_ADDR    in   host event address
//   HOST_READY   out  host slot empty
//   AEROUT_ADDR  out  address presented on the link
//   AEROUT_REQ   out  four-phase request
//   AEROUT_ACK   in   four-phase acknowledge (already in the CLK domain)
//   GRANT_HOST   out  current/last transfer belongs to the host
//   ERR          out  sticky handshake timeout flag
//   ERR_CLR      in   clears ERR / leaves ERROR once the link is idle
//   EVT_CNT      out  saturating completed-transfer count
//   CLR_CNT      in   synchronous EVT_CNT clear (wins over an increment)
// ---------------------------------------------------------------------------
module aer_link_arbiter
    import aer_pkg::*;
#(
    parameter int ADDR_W      = AER_ADDR_W_DEFAULT,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              ENC_VALID,
    input  logic [ADDR_W-1:0] ENC_ADDR,
    output logic              ENC_READY,
    input  logic              HOST_VALID,
    input  logic [ADDR_W-1:0] HOST_ADDR,
    output logic              HOST_READY,
    output logic [ADDR_W-1:0] AEROUT_ADDR,
    output logic              AEROUT_REQ,
    input  logic              AEROUT_ACK,
    output logic              GRANT_HOST,
    output logic              ERR,
    input  logic              ERR_CLR,
    output logic [15:0]       EVT_CNT,
    input  logic              CLR_CNT
);

    localparam int               TMR_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    // Last timer value of a phase: the phase has then lasted TIMEOUT_CYC cycles.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [15:0]      CNT_MAX  = 16'hFFFF;

    // ---------------------------------------------------------------------
    // Requester slots, indexed by req_id_t (0 = encoder, 1 = host)
    // ---------------------------------------------------------------------
    logic [1:0]        slot_in_valid;
    logic [1:0]        slot_ready;
    logic [1:0]        slot_full;
    logic [1:0]        slot_drop;
    logic [ADDR_W-1:0] slot_in_addr [2];
    logic [ADDR_W-1:0] slot_addr    [2];

    assign slot_in_valid   = {HOST_VALID, ENC_VALID};
    assign slot_in_addr[0] = ENC_ADDR;
    assign slot_in_addr[1] = HOST_ADDR;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            aer_req_slot #(
                .ADDR_W (ADDR_W)
            ) u_slot (
                .CLK      (CLK),
                .RSTN     (RSTN),
                .IN_VALID (slot_in_valid[gi]),
                .IN_ADDR  (slot_in_addr[gi]),
                .IN_READY (slot_ready[gi]),
                .DROP     (slot_drop[gi]),
                .FULL     (slot_full[gi]),
                .ADDR     (slot_addr[gi])
            );
        end
    endgenerate

    assign ENC_READY  = slot_ready[0];
    assign HOST_READY = slot_ready[1];

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    aer_state_t        state_reg,   state_next;
    req_id_t           grant_reg,   grant_next;
    req_id_t           prefer_reg,  prefer_next;
    logic [ADDR_W-1:0] addr_reg,    addr_next;
    logic [TMR_W-1:0]  timer_reg,   timer_next;
    logic              err_reg,     err_next;
    logic [15:0]       evt_cnt_reg, evt_cnt_next;

    req_id_t arb_pick;
    logic    phase_timeout;
    logic    arb_load;
    logic    xfer_done;
    logic    xfer_abort;

    assign arb_pick      = rr_pick(slot_full[0], slot_full[1], prefer_reg);
    assign phase_timeout = (timer_reg == TMR_LAST);

    // FSM state register
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            // A still-high ACK means the receiver has not finished the
            // previous handshake; wait for it before starting a new one.
            IDLE: begin
                if ((slot_full != 2'b00) && !AEROUT_ACK) begin
                    state_next = ARB;
                end
            end
            ARB: begin
                state_next = REQ_HI;
            end
            REQ_HI: begin
                if (AEROUT_ACK) begin
                    state_next = REQ_LO;
                end else if (phase_timeout) begin
                    state_next = ERROR;
                end
            end
            REQ_LO: begin
                if (!AEROUT_ACK) begin
                    state_next = IDLE;
                end else if (phase_timeout) begin
                    state_next = ERROR;
                end
            end
            ERROR: begin
                if (ERR_CLR && !AEROUT_ACK) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM outputs and per-state strobes
    always_comb begin
        AEROUT_REQ = 1'b0;
        arb_load   = 1'b0;
        xfer_done  = 1'b0;
        xfer_abort = 1'b0;
        case (state_reg)
            ARB: begin
                arb_load = 1'b1;
            end
            REQ_HI: begin
                AEROUT_REQ = 1'b1;
                xfer_abort = !AEROUT_ACK && phase_timeout;
            end
            REQ_LO: begin
                xfer_done  = !AEROUT_ACK;
                xfer_abort = AEROUT_ACK && phase_timeout;
            end
            default: begin
            end
        endcase
    end

    // The winner leaves its slot on completion and on timeout; the other
    // slot is untouched either way.
    assign slot_drop[0] = (xfer_done || xfer_abort) && (grant_reg == REQ_ENC);
    assign slot_drop[1] = (xfer_done || xfer_abort) && (grant_reg == REQ_HOST);

    // Datapath next-state logic
    always_comb begin
        grant_next   = grant_reg;
        prefer_next  = prefer_reg;
        addr_next    = addr_reg;
        timer_next   = timer_reg;
        err_next     = err_reg;
        evt_cnt_next = evt_cnt_reg;

        // Address and grant are frozen from here until the handshake ends.
        if (arb_load) begin
            grant_next = arb_pick;
            addr_next  = slot_addr[arb_pick];
        end

        // Restart on every state change so REQ_HI and REQ_LO each get the
        // full budget; count only while a handshake phase is open.
        if (state_next != state_reg) begin
            timer_next = '0;
        end else if ((state_reg == REQ_HI) || (state_reg == REQ_LO)) begin
            timer_next = timer_reg + 1'b1;
        end

        if (xfer_abort) begin
            err_next = 1'b1;
        end else if ((state_reg == ERROR) && (state_next == IDLE)) begin
            err_next = 1'b0;
        end

        // Only completed transfers move the round-robin pointer.
        if (xfer_done) begin
            prefer_next = (grant_reg == REQ_ENC) ? REQ_HOST : REQ_ENC;
        end

        if (CLR_CNT) begin
            evt_cnt_next = '0;
        end else if (xfer_done && (evt_cnt_reg != CNT_MAX)) begin
            evt_cnt_next = evt_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            grant_reg   <= REQ_ENC;
            prefer_reg  <= REQ_ENC;
            addr_reg    <= '0;
            timer_reg   <= '0;
            err_reg     <= 1'b0;
            evt_cnt_reg <= '0;
        end else begin
            grant_reg   <= grant_next;
            prefer_reg  <= prefer_next;
            addr_reg    <= addr_next;
            timer_reg   <= timer_next;
            err_reg     <= err_next;
            evt_cnt_reg <= evt_cnt_next;
        end
    end

    assign AEROUT_ADDR = addr_reg;
    assign GRANT_HOST  = (grant_reg == REQ_HOST);
    assign ERR         = err_reg;
    assign EVT_CNT     = evt_cnt_reg;

endmodule

// File: tb/tb_aer_link_arbiter.sv
// ---------------------------------------------------------------------------
// tb_aer_link_arbiter
// Directed bench for aer_link_arbiter. Each offered event pushes its
// expected grant/address into a queue; a monitor pops and compares on every
// rising AEROUT_REQ and checks the address stays put while REQ is high.
// A responder process mirrors REQ onto ACK one half-cycle later unless the
// main sequence takes manual control of ACK.
// ---------------------------------------------------------------------------
module tb_aer_link_arbiter;

    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 1023;

    logic              CLK = 1'b0;
    logic              RSTN = 1'b0;
    logic              ENC_VALID = 1'b0;
    logic [ADDR_W-1:0] ENC_ADDR = '0;
    logic              ENC_READY;
    logic              HOST_VALID = 1'b0;
    logic [ADDR_W-1:0] HOST_ADDR = '0;
    logic              HOST_READY;
    logic [ADDR_W-1:0] AEROUT_ADDR;
    logic              AEROUT_REQ;
    logic              AEROUT_ACK;
    logic              GRANT_HOST;
    logic              ERR;
    logic              ERR_CLR = 1'b0;
    logic [15:0]       EVT_CNT;
    logic              CLR_CNT = 1'b0;

    logic auto_ack   = 1'b1;
    logic ack_auto   = 1'b0;
    logic ack_manual = 1'b0;
    assign AEROUT_ACK = auto_ack ? ack_auto : ack_manual;

    aer_link_arbiter #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .ENC_VALID   (ENC_VALID),
        .ENC_ADDR    (ENC_ADDR),
        .ENC_READY   (ENC_READY),
        .HOST_VALID  (HOST_VALID),
        .HOST_ADDR   (HOST_ADDR),
        .HOST_READY  (HOST_READY),
        .AEROUT_ADDR (AEROUT_ADDR),
        .AEROUT_REQ  (AEROUT_REQ),
        .AEROUT_ACK  (AEROUT_ACK),
        .GRANT_HOST  (GRANT_HOST),
        .ERR         (ERR),
        .ERR_CLR     (ERR_CLR),
        .EVT_CNT     (EVT_CNT),
        .CLR_CNT     (CLR_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic              host;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rise_cnt = 0;
    int   last_rise_cyc = 0;
    int   prev_rise_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // ACK follows REQ half a cycle later
    initial forever begin
        @(negedge CLK);
        ack_auto = AEROUT_REQ;
    end

    // Scoreboard monitor
    initial begin
        exp_t cur;
        logic req_prev;
        req_prev = 1'b0;
        cur.host = 1'b0;
        cur.addr = '0;
        forever begin
            @(negedge CLK);
            if (AEROUT_REQ && !req_prev) begin
                rise_cnt++;
                prev_rise_cyc = last_rise_cyc;
                last_rise_cyc = cyc;
                check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    check("sb_grant_host", 32'(GRANT_HOST), 32'(cur.host));
                    check("sb_addr", 32'(AEROUT_ADDR), 32'(cur.addr));
                end
            end else if (AEROUT_REQ) begin
                check("addr_stable", 32'(AEROUT_ADDR), 32'(cur.addr));
            end
            req_prev = AEROUT_REQ;
        end
    end

    task automatic send(input logic host, input logic [ADDR_W-1:0] addr);
        exp_t e;
        @(negedge CLK);
        if (host) begin
            check("host_ready_before", 32'(HOST_READY), 32'd1);
            HOST_VALID = 1'b1;
            HOST_ADDR  = addr;
        end else begin
            check("enc_ready_before", 32'(ENC_READY), 32'd1);
            ENC_VALID = 1'b1;
            ENC_ADDR  = addr;
        end
        e.host = host;
        e.addr = addr;
        exp_q.push_back(e);
        @(negedge CLK);
        ENC_VALID  = 1'b0;
        HOST_VALID = 1'b0;
    endtask

    // Both offered on the same edge; a fresh pointer serves the encoder first.
    task automatic send_both(input logic [ADDR_W-1:0] enc_a, input logic [ADDR_W-1:0] host_a);
        exp_t e;
        @(negedge CLK);
        ENC_VALID  = 1'b1;
        ENC_ADDR   = enc_a;
        HOST_VALID = 1'b1;
        HOST_ADDR  = host_a;
        e.host = 1'b0;
        e.addr = enc_a;
        exp_q.push_back(e);
        e.host = 1'b1;
        e.addr = host_a;
        exp_q.push_back(e);
        @(negedge CLK);
        ENC_VALID  = 1'b0;
        HOST_VALID = 1'b0;
    endtask

    task automatic wait_cnt(input string tag, input logic [15:0] target);
        int n;
        n = 0;
        while (EVT_CNT !== target && n < 60) begin
            @(negedge CLK);
            n++;
        end
        check(tag, 32'(EVT_CNT), 32'(target));
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (AEROUT_REQ !== 1'b1 && n < 60) begin
            @(negedge CLK);
            n++;
        end
        check(tag, 32'(AEROUT_REQ), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RSTN = 1'b0;
        repeat (2) @(negedge CLK);
        RSTN = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int n;

        // ---- reset state ----
        repeat (2) @(negedge CLK);
        check("rst_req", 32'(AEROUT_REQ), 32'd0);
        check("rst_addr", 32'(AEROUT_ADDR), 32'd0);
        check("rst_enc_ready", 32'(ENC_READY), 32'd1);
        check("rst_host_ready", 32'(HOST_READY), 32'd1);
        check("rst_grant", 32'(GRANT_HOST), 32'd0);
        check("rst_err", 32'(ERR), 32'd0);
        check("rst_cnt", 32'(EVT_CNT), 32'd0);
        RSTN = 1'b1;

        // ---- single encoder event, latency and one REQ pulse ----
        r0 = rise_cnt;
        send(1'b0, 10'h1FF);
        check("single_enc_slot_full", 32'(ENC_READY), 32'd0);
        check("single_req_n0", 32'(AEROUT_REQ), 32'd0);
        @(negedge CLK);
        check("single_req_n1", 32'(AEROUT_REQ), 32'd0);
        @(negedge CLK);
        check("single_req_n2", 32'(AEROUT_REQ), 32'd1);
        wait_cnt("single_cnt", 16'd1);
        repeat (3) @(negedge CLK);
        check("single_pulses", 32'(rise_cnt - r0), 32'd1);
        check("single_grant", 32'(GRANT_HOST), 32'd0);
        check("single_enc_ready", 32'(ENC_READY), 32'd1);

        // ---- simultaneous requests, round robin, back-to-back period ----
        do_reset();
        send_both(10'h005, 10'h2A0);
        wait_cnt("rr_cnt2", 16'd2);
        check("rr_period", 32'(last_rise_cyc - prev_rise_cyc), 32'd4);
        send_both(10'h005, 10'h2A0);
        wait_cnt("rr_cnt4", 16'd4);
        check("rr_queue_drained", 32'(exp_q.size()), 32'd0);

        // ---- handshake timeout, host held across the error ----
        auto_ack   = 1'b0;
        ack_manual = 1'b0;
        send(1'b0, 10'h155);
        wait_req("to_req");
        send(1'b1, 10'h0AA);
        check("to_host_held", 32'(HOST_READY), 32'd0);
        n = 0;
        while (ERR !== 1'b1 && n < TIMEOUT + 100) begin
            @(negedge CLK);
            n++;
        end
        check("to_err", 32'(ERR), 32'd1);
        check("to_req_cycles", 32'(cyc - last_rise_cyc), 32'(TIMEOUT));
        check("to_req_low", 32'(AEROUT_REQ), 32'd0);
        check("to_enc_dropped", 32'(ENC_READY), 32'd1);
        check("to_host_kept", 32'(HOST_READY), 32'd0);
        ack_manual = 1'b1;
        ERR_CLR    = 1'b1;
        @(negedge CLK);
        ERR_CLR = 1'b0;
        @(negedge CLK);
        check("to_clr_blocked_by_ack", 32'(ERR), 32'd1);
        ack_manual = 1'b0;
        auto_ack   = 1'b1;
        repeat (2) @(negedge CLK);
        check("to_err_sticky", 32'(ERR), 32'd1);
        check("to_no_req_in_error", 32'(AEROUT_REQ), 32'd0);
        ERR_CLR = 1'b1;
        @(negedge CLK);
        ERR_CLR = 1'b0;
        check("to_err_cleared", 32'(ERR), 32'd0);
        wait_cnt("to_host_after_clr", 16'd5);

        // ---- ACK high in IDLE holds off a pending host event ----
        auto_ack   = 1'b0;
        ack_manual = 1'b1;
        r0 = rise_cnt;
        send(1'b1, 10'h3C3);
        repeat (6) @(negedge CLK);
        check("ackhi_no_req", 32'(rise_cnt - r0), 32'd0);
        check("ackhi_cnt_hold", 32'(EVT_CNT), 32'd5);
        ack_manual = 1'b0;
        auto_ack   = 1'b1;
        wait_cnt("ackhi_cnt", 16'd6);
        check("ackhi_grant", 32'(GRANT_HOST), 32'd1);

        // ---- reset in the middle of REQ_HI ----
        auto_ack   = 1'b0;
        ack_manual = 1'b0;
        send(1'b0, 10'h111);
        wait_req("rstmid_req");
        RSTN = 1'b0;
        #1;
        check("rstmid_req_low", 32'(AEROUT_REQ), 32'd0);
        check("rstmid_cnt", 32'(EVT_CNT), 32'd0);
        check("rstmid_enc_ready", 32'(ENC_READY), 32'd1);
        check("rstmid_host_ready", 32'(HOST_READY), 32'd1);
        check("rstmid_addr", 32'(AEROUT_ADDR), 32'd0);
        @(negedge CLK);
        RSTN     = 1'b1;
        auto_ack = 1'b1;
        r0 = rise_cnt;
        repeat (6) @(negedge CLK);
        check("rstmid_event_dropped", 32'(rise_cnt - r0), 32'd0);
        check("rstmid_cnt_after", 32'(EVT_CNT), 32'd0);

        // ---- counter saturation and clear-vs-increment priority ----
        // Preload near the top; walking the counter there would take
        // hundreds of thousands of cycles.
        @(negedge CLK);
        dut.evt_cnt_reg = 16'hFFFE;
        @(negedge CLK);
        check("sat_preload", 32'(EVT_CNT), 32'hFFFE);
        send(1'b0, 10'h001);
        wait_cnt("sat_reach", 16'hFFFF);
        send(1'b1, 10'h002);
        wait_req("sat_req");
        repeat (2) @(negedge CLK);
        check("sat_done", 32'(HOST_READY), 32'd1);
        check("sat_hold", 32'(EVT_CNT), 32'hFFFF);
        send(1'b0, 10'h003);
        wait_req("clr_req");
        @(negedge CLK);
        check("clr_before", 32'(EVT_CNT), 32'hFFFF);
        CLR_CNT = 1'b1;
        @(negedge CLK);
        CLR_CNT = 1'b0;
        check("clr_done", 32'(ENC_READY), 32'd1);
        check("clr_wins", 32'(EVT_CNT), 32'd0);
        repeat (2) @(negedge CLK);
        check("clr_stays", 32'(EVT_CNT), 32'd0);
        check("final_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
